// File: rtl/dma_ext_pkg.sv
// Shared types and defaults for the clocked DMA external device.
package dma_ext_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_FIRE = 3'd2,
        ST_BUSY = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int WORD_SIZE_DEF = 16;

    // Width needed to address n blocks; never narrower than one bit.
    function automatic int offset_bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dma_ext_storage.sv
// Block register file: registered read port, gated write port, out-of-range guard.
module dma_ext_storage
    import dma_ext_pkg::*;
#(
    parameter int BLOCK_W     = 64,
    parameter int NUM_BLOCKS  = 3,
    parameter int OFFSET_BITS = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [OFFSET_BITS-1:0] i_rd_addr,
    output logic [BLOCK_W-1:0]     o_rd_data,
    input  logic                   i_wr_en,
    input  logic [OFFSET_BITS-1:0] i_wr_addr,
    input  logic [BLOCK_W-1:0]     i_wr_data
);

    logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] r_mem;
    logic [BLOCK_W-1:0]                 r_rd_data;
    logic [BLOCK_W-1:0]                 w_rd_data;

    // Addresses matching no block read as zero.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (i_rd_addr == OFFSET_BITS'(i)) w_rd_data = r_mem[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_rd_data <= '0;
        else         r_rd_data <= w_rd_data;
    end

    // Contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (i_wr_en && (i_wr_addr == OFFSET_BITS'(i))) r_mem[i] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dma_ext_device.sv
// Clocked external device: timed interrupt, holds data until DMA completion, repeats.
module dma_ext_device
    import dma_ext_pkg::*;
#(
    parameter int WORD_SIZE     = WORD_SIZE_DEF,
    parameter int BURST_WORDS   = 4,
    parameter int NUM_BLOCKS    = 3,
    parameter int OFFSET_BITS   = offset_bits_for(NUM_BLOCKS),
    parameter int FIRE_INTERVAL = 36000,
    parameter int INT_DURATION  = 100,
    parameter int NUM_FIRES     = 2,
    parameter int CNT_BITS      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [OFFSET_BITS-1:0]           offset,
    output logic [BURST_WORDS*WORD_SIZE-1:0] data,
    output logic                             interrupt,
    input  logic                             dma_done,
    input  logic                             wr_en,
    input  logic [OFFSET_BITS-1:0]           wr_addr,
    input  logic [BURST_WORDS*WORD_SIZE-1:0] wr_data,
    output logic                             busy,
    output logic [7:0]                       fire_count,
    output logic                             protocol_err
);

    localparam logic [CNT_BITS-1:0] FIRE_LAST = CNT_BITS'(FIRE_INTERVAL - 1);
    localparam logic [CNT_BITS-1:0] INT_LAST  = CNT_BITS'(INT_DURATION - 1);
    localparam logic [7:0]          FIRE_TGT  = 8'(NUM_FIRES);

    state_t              r_state, w_next;
    logic [CNT_BITS-1:0] r_cnt, w_cnt_next;
    logic [7:0]          r_fires, w_fires_inc;
    logic                r_int, r_busy, r_perr;
    logic                w_xfer, w_done_ok, w_wr_ok;

    assign w_xfer      = (r_state == ST_FIRE) || (r_state == ST_BUSY);
    assign w_done_ok   = dma_done && w_xfer;
    assign w_fires_inc = (r_fires == 8'hFF) ? r_fires : r_fires + 8'd1;
    assign w_wr_ok     = wr_en && !w_xfer;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (enable) w_next = ST_WAIT;
            end
            // Dropping enable wins over an interval that expires the same cycle.
            ST_WAIT: begin
                if (!enable) begin
                    w_next     = ST_IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt == FIRE_LAST) begin
                    w_next     = ST_FIRE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_FIRE: begin
                if (r_cnt == INT_LAST) begin
                    w_next     = ST_BUSY;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_BUSY: w_cnt_next = '0;
            ST_DONE: w_cnt_next = '0;
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase
        // Completion overrides the FIRE timeout and cuts the interrupt short.
        if (w_done_ok) begin
            w_cnt_next = '0;
            w_next     = ((NUM_FIRES != 0) && (w_fires_inc == FIRE_TGT)) ? ST_DONE : ST_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fires <= '0;
            r_int   <= 1'b0;
            r_busy  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_done_ok) r_fires <= w_fires_inc;
            if (dma_done && !w_xfer) r_perr <= 1'b1;
            r_int   <= (w_next == ST_FIRE);
            r_busy  <= (w_next == ST_FIRE) || (w_next == ST_BUSY);
        end
    end

    dma_ext_storage #(
        .BLOCK_W    (BURST_WORDS*WORD_SIZE),
        .NUM_BLOCKS (NUM_BLOCKS),
        .OFFSET_BITS(OFFSET_BITS)
    ) u_storage (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_rd_addr(offset),
        .o_rd_data(data),
        .i_wr_en  (w_wr_ok),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data)
    );

    assign interrupt    = r_int;
    assign busy         = r_busy;
    assign fire_count   = r_fires;
    assign protocol_err = r_perr;

endmodule

// File: tb/tb_dma_ext_device.sv
// Self-checking bench: storage array model plus edge-count timing expectations.
module tb_dma_ext_device;

    localparam int FI = 10, ID = 3, NF = 2, NB = 3, OB = 2, DW = 64;

    logic          clk = 1'b0;
    logic          reset, enable, dma_done, wr_en;
    logic [OB-1:0] offset, wr_addr;
    logic [DW-1:0] wr_data, data;
    logic          interrupt, busy, protocol_err;
    logic [7:0]    fire_count;

    logic [DW-1:0] mem_m [NB];
    int checks = 0, passes = 0;

    dma_ext_device #(
        .WORD_SIZE(16), .BURST_WORDS(4), .NUM_BLOCKS(NB), .OFFSET_BITS(OB),
        .FIRE_INTERVAL(FI), .INT_DURATION(ID), .NUM_FIRES(NF), .CNT_BITS(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .offset(offset), .data(data),
        .interrupt(interrupt), .dma_done(dma_done), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .fire_count(fire_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [OB-1:0] a);
        return (int'(a) < NB) ? mem_m[int'(a)] : '0;
    endfunction

    task automatic model_wr(input logic en, input logic [OB-1:0] a, input logic [DW-1:0] d);
        if (en && int'(a) < NB) mem_m[int'(a)] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; dma_done = 1'b0; wr_en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; dma_done = 1'b0; wr_en = 1'b0;
        offset = '0; wr_addr = '0; wr_data = '0;
        step(); step();
        checks++; if (data !== '0) $display("FAIL reset_data got %h exp 0", data); else passes++;
        checks++; if (interrupt !== 1'b0) $display("FAIL reset_irq got %b exp 0", interrupt); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else passes++;
        checks++; if (fire_count !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", fire_count); else passes++;
        checks++; if (protocol_err !== 1'b0) $display("FAIL reset_perr got %b exp 0", protocol_err); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_storage();
        logic [DW-1:0] pat [3] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
        logic [DW-1:0] exp;
        for (int b = 0; b < NB; b++) begin
            wr_en = 1'b1; wr_addr = OB'(b); wr_data = pat[b];
            model_wr(1'b1, OB'(b), pat[b]);
            step();
        end
        wr_en = 1'b0;
        offset = 2'd0; step();
        offset = 2'd1;
        checks++; if (data !== 64'h1111_1111_1111_1111) $display("FAIL rd_hold got %h exp 1111..", data); else passes++;
        step();
        checks++; if (data !== 64'h2222_2222_2222_2222) $display("FAIL rd_blk1 got %h exp 2222..", data); else passes++;
        offset = 2'd3; step();
        checks++; if (data !== '0) $display("FAIL rd_oob got %h exp 0", data); else passes++;
        // Same-cycle write to the block being read returns old data first.
        offset = 2'd2; step();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = {$urandom, $urandom};
        model_wr(1'b1, 2'd2, wr_data);
        step();
        wr_en = 1'b0;
        checks++; if (data !== 64'h3333_3333_3333_3333) $display("FAIL rd_old got %h exp 3333..", data); else passes++;
        step();
        checks++; if (data !== mem_m[2]) $display("FAIL rd_new got %h exp %h", data, mem_m[2]); else passes++;
        for (int i = 0; i < 24; i++) begin
            offset = OB'($urandom_range(0, 3)); wr_en = 1'($urandom_range(0, 1));
            wr_addr = OB'($urandom_range(0, 3)); wr_data = {$urandom, $urandom};
            exp = model_rd(offset);
            model_wr(wr_en, wr_addr, wr_data);
            step();
            checks++; if (data !== exp) $display("FAIL rd_rand i=%0d got %h exp %h", i, data, exp); else passes++;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_fire_sequence();
        int bad;
        do_reset();
        offset = 2'd0;
        enable = 1'b1; step();
        for (int k = 1; k <= FI + ID + 2; k++) begin
            step();
            checks++; if (interrupt !== (k >= FI && k < FI + ID)) $display("FAIL seq1_irq k=%0d got %b", k, interrupt); else passes++;
            checks++; if (busy !== (k >= FI)) $display("FAIL seq1_busy k=%0d got %b", k, busy); else passes++;
        end
        // Write while busy must be dropped.
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = ~mem_m[0]; step(); wr_en = 1'b0;
        for (int i = 0; i < int'($urandom_range(2, 8)); i++) begin
            step();
            checks++; if (busy !== 1'b1 || data !== mem_m[0]) $display("FAIL busy_hold got busy=%b data=%h exp 1 %h", busy, data, mem_m[0]); else passes++;
        end
        dma_done = 1'b1; step(); dma_done = 1'b0;
        checks++; if (fire_count !== 8'd1) $display("FAIL seq_cnt1 got %0d exp 1", fire_count); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL seq_busy_clr got %b exp 0", busy); else passes++;
        for (int k = 1; k <= FI + ID; k++) begin
            wr_en = (k <= 2); wr_addr = (k == 1) ? 2'd0 : 2'd3; wr_data = {$urandom, $urandom};
            if (k == 1) model_wr(1'b1, 2'd0, wr_data);
            step();
            wr_en = 1'b0;
            checks++; if (interrupt !== (k >= FI && k < FI + ID)) $display("FAIL seq2_irq k=%0d got %b", k, interrupt); else passes++;
            if (k >= 3) begin
                checks++; if (data !== mem_m[0]) $display("FAIL wait_wr k=%0d got %h exp %h", k, data, mem_m[0]); else passes++;
            end
        end
        dma_done = 1'b1; step(); dma_done = 1'b0;
        checks++; if (fire_count !== 8'd2) $display("FAIL seq_cnt2 got %0d exp 2", fire_count); else passes++;
        bad = 0;
        for (int k = 0; k < 2 * FI + ID; k++) begin
            step();
            if (interrupt !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL done_quiet got %0d active cycles exp 0", bad); else passes++;
        checks++; if (protocol_err !== 1'b0) $display("FAIL seq_perr got %b exp 0", protocol_err); else passes++;
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = {$urandom, $urandom};
        model_wr(1'b1, 2'd1, wr_data);
        step(); wr_en = 1'b0; offset = 2'd1; step();
        checks++; if (data !== mem_m[1]) $display("FAIL done_wr got %h exp %h", data, mem_m[1]); else passes++;
    endtask

    task automatic test_early_done();
        do_reset();
        enable = 1'b1; step();
        for (int k = 1; k <= FI + 1; k++) step();
        checks++; if (interrupt !== 1'b1) $display("FAIL early_pre got %b exp 1", interrupt); else passes++;
        dma_done = 1'b1; step(); dma_done = 1'b0;
        checks++; if (interrupt !== 1'b0) $display("FAIL early_irq got %b exp 0", interrupt); else passes++;
        checks++; if (fire_count !== 8'd1) $display("FAIL early_cnt got %0d exp 1", fire_count); else passes++;
        for (int k = 1; k <= FI + 1; k++) begin
            step();
            checks++; if (interrupt !== (k >= FI)) $display("FAIL early_next k=%0d got %b", k, interrupt); else passes++;
        end
    endtask

    task automatic test_protocol_err();
        do_reset();
        enable = 1'b1; step();
        for (int k = 1; k <= 3; k++) step();
        dma_done = 1'b1; step(); dma_done = 1'b0;
        checks++; if (protocol_err !== 1'b1) $display("FAIL perr_set got %b exp 1", protocol_err); else passes++;
        checks++; if (fire_count !== 8'd0) $display("FAIL perr_cnt got %0d exp 0", fire_count); else passes++;
        for (int k = 5; k <= FI; k++) begin
            step();
            checks++; if (interrupt !== (k >= FI)) $display("FAIL perr_timing k=%0d got %b", k, interrupt); else passes++;
        end
        for (int k = 0; k < ID + 2; k++) step();
        checks++; if (protocol_err !== 1'b1) $display("FAIL perr_sticky got %b exp 1", protocol_err); else passes++;
    endtask

    task automatic test_reset_mid_fire();
        do_reset();
        enable = 1'b1; step();
        for (int k = 1; k <= FI + 1; k++) step();
        dma_done = 1'b1; step(); dma_done = 1'b0;
        for (int k = 1; k <= FI + 1; k++) step();
        checks++; if (fire_count !== 8'd1 || interrupt !== 1'b1) $display("FAIL pre_rst got cnt=%0d irq=%b exp 1 1", fire_count, interrupt); else passes++;
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (interrupt !== 1'b0 || busy !== 1'b0) $display("FAIL rst_irq got irq=%b busy=%b exp 0 0", interrupt, busy); else passes++;
        checks++; if (fire_count !== 8'd0) $display("FAIL rst_cnt got %0d exp 0", fire_count); else passes++;
        // From IDLE the enable edge costs one extra cycle before the interval.
        for (int k = 1; k <= FI + 1; k++) begin
            step();
            checks++; if (interrupt !== (k == FI + 1)) $display("FAIL rst_idle k=%0d got %b", k, interrupt); else passes++;
        end
        for (int b = 0; b < NB; b++) begin
            offset = OB'(b); step();
            checks++; if (data !== mem_m[b]) $display("FAIL rst_keep b=%0d got %h exp %h", b, data, mem_m[b]); else passes++;
        end
    endtask

    task automatic test_enable_drop();
        int bad;
        do_reset();
        enable = 1'b1; step();
        for (int k = 1; k <= FI - 1; k++) step();
        enable = 1'b0; step();
        checks++; if (interrupt !== 1'b0) $display("FAIL endrop_irq got %b exp 0", interrupt); else passes++;
        bad = 0;
        for (int k = 0; k < 2 * FI; k++) begin
            step();
            if (interrupt !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL endrop_quiet got %0d active cycles exp 0", bad); else passes++;
        enable = 1'b1; step();
        for (int k = 1; k <= FI; k++) begin
            step();
            checks++; if (interrupt !== (k == FI)) $display("FAIL endrop_rearm k=%0d got %b", k, interrupt); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_storage();
        test_fire_sequence();
        test_early_done();
        test_protocol_err();
        test_reset_mid_fire();
        test_enable_drop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
